// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - registered bitwise 2-input logic unit with stream handshake and burst accumulate
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic             in_acc,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_o,
    output logic [CNT_W-1:0] out_cnt
);

    localparam logic [1:0] OP_OR   = 2'd0;
    localparam logic [1:0] OP_AND  = 2'd1;
    localparam logic [1:0] OP_NAND = 2'd2;
    localparam logic [1:0] OP_XOR  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [1:0]       op_q;
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic [WIDTH-1:0] first_res;
    logic [WIDTH-1:0] acc_next;
    logic [CNT_W-1:0] cnt_next;

    function automatic logic [WIDTH-1:0] apply_op(
        input logic [1:0]       op,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y
    );
        logic [WIDTH-1:0] r;
        case (op)
            OP_OR:   r = x | y;
            OP_AND:  r = x & y;
            OP_NAND: r = ~(x & y);
            OP_XOR:  r = x ^ y;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Accept whenever the output slot is empty or is being drained this cycle
    always_comb begin
        in_ready = !out_valid || out_ready;
        accept   = in_valid && in_ready;
    end

    // Candidate results: a fresh operation on both operands, and a fold of in_a into the running accumulator
    always_comb begin
        first_res = apply_op(in_op, in_a, in_b);
        acc_next  = apply_op(op_q, acc, in_a);
        cnt_next  = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    end

    // Control FSM and registered result; a new result may load in the same cycle the old one drains
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            op_q      <= OP_OR;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_o     <= '0;
            out_cnt   <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                case (state)
                    IDLE: begin
                        if (in_acc) begin
                            op_q <= in_op;
                            acc  <= first_res;
                            cnt  <= CNT_ONE;
                        end
                        if (!in_acc || in_last) begin
                            out_o     <= first_res;
                            out_cnt   <= CNT_ONE;
                            out_valid <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            state <= ACC;
                        end
                    end
                    ACC: begin
                        if (in_last) begin
                            out_o     <= acc_next;
                            out_cnt   <= cnt_next;
                            out_valid <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            acc <= acc_next;
                            cnt <= cnt_next;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
